// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver: state encoding, frame width
// and the mid-bit sampling offset.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        CLEANUP   = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_rx_state_t;

    // Clocks from the detected start edge to the middle of the start bit.
    function automatic int half_bit_count(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic r_Meta;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_Meta <= 1'b1;
            o_Sync <= 1'b1;
        end else begin
            r_Meta <= i_Async;
            o_Sync <= r_Meta;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_less.sv
// 8N1 serial receiver with a single holding register, mid-bit sampling,
// framing-error and overrun reporting.
module uart_rx_fifo_less
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    input  logic       i_Rx_Ack,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_DV,
    output logic       o_Rx_Ready,
    output logic       o_Rx_Overrun,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_bit_count(CLKS_PER_BIT));
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    logic                 r_Rx;
    uart_rx_state_t       r_State;
    logic [CNT_W-1:0]     r_Count;
    logic [2:0]           r_Index;
    logic [DATA_BITS-1:0] r_Shift;

    uart_rx_sync u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Async (i_Rx_Serial),
        .o_Sync  (r_Rx)
    );

    assign o_Rx_Busy = (r_State != IDLE);

    // Handshake: o_Rx_Ready is the valid level for o_Rx_Byte; i_Rx_Ack is
    // sampled on the same edge that may latch a new byte. Ack clears Ready and
    // Overrun, but a byte latched on that same edge wins and keeps Ready high;
    // a byte latched while Ready is high and unacked sets sticky Overrun.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_State        <= IDLE;
            r_Count        <= '0;
            r_Index        <= '0;
            r_Shift        <= '0;
            o_Rx_Byte      <= '0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Ready     <= 1'b0;
            o_Rx_Overrun   <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            if (i_Rx_Ack) begin
                o_Rx_Ready   <= 1'b0;
                o_Rx_Overrun <= 1'b0;
            end

            case (r_State)
                IDLE: begin
                    r_Count <= '0;
                    r_Index <= '0;
                    if (!r_Rx) begin
                        r_State <= START;
                    end
                end

                START: begin
                    if (r_Count == CNT_HALF) begin
                        r_Count <= '0;
                        r_State <= r_Rx ? IDLE : DATA;
                    end else begin
                        r_Count <= r_Count + 1'b1;
                    end
                end

                DATA: begin
                    if (r_Count == CNT_LAST) begin
                        r_Count          <= '0;
                        r_Shift[r_Index] <= r_Rx;
                        if (r_Index == IDX_LAST) begin
                            r_Index <= '0;
                            r_State <= STOP;
                        end else begin
                            r_Index <= r_Index + 1'b1;
                        end
                    end else begin
                        r_Count <= r_Count + 1'b1;
                    end
                end

                STOP: begin
                    if (r_Count == CNT_LAST) begin
                        r_Count <= '0;
                        if (r_Rx) begin
                            o_Rx_Byte  <= r_Shift;
                            o_Rx_DV    <= 1'b1;
                            o_Rx_Ready <= 1'b1;
                            if (o_Rx_Ready && !i_Rx_Ack) begin
                                o_Rx_Overrun <= 1'b1;
                            end
                            r_State <= CLEANUP;
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                            r_State        <= WAIT_HIGH;
                        end
                    end else begin
                        r_Count <= r_Count + 1'b1;
                    end
                end

                // Single cycle so a start bit right after the stop bit is still seen.
                CLEANUP: begin
                    r_State <= IDLE;
                end

                // A held-low line (break) must not be mistaken for new start bits.
                WAIT_HIGH: begin
                    if (r_Rx) begin
                        r_State <= IDLE;
                    end
                end

                default: begin
                    r_State <= IDLE;
                    r_Count <= '0;
                    r_Index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_less.sv
// Directed bench for uart_rx_fifo_less: frames are scheduled into an expected
// queue at the documented latency and a per-cycle compare checks every output.
module tb_uart_rx_fifo_less;

  localparam int CLKS = 16;
  localparam int LAT  = 155;  // 2 + 1 + 7 + 9*16 + 1
  localparam int W    = 41;   // {event cycle[31:0], good stop, byte[7:0]}

  logic       i_Clock     = 1'b0;
  logic       i_Rst_n     = 1'b0;
  logic       i_Rx_Serial = 1'b1;
  logic       i_Rx_Ack    = 1'b0;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_DV;
  logic       o_Rx_Ready;
  logic       o_Rx_Overrun;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Busy;

  uart_rx_fifo_less #(.CLKS_PER_BIT(CLKS)) dut (
    .i_Clock        (i_Clock),
    .i_Rst_n        (i_Rst_n),
    .i_Rx_Serial    (i_Rx_Serial),
    .i_Rx_Ack       (i_Rx_Ack),
    .o_Rx_Byte      (o_Rx_Byte),
    .o_Rx_DV        (o_Rx_DV),
    .o_Rx_Ready     (o_Rx_Ready),
    .o_Rx_Overrun   (o_Rx_Overrun),
    .o_Rx_Frame_Err (o_Rx_Frame_Err),
    .o_Rx_Busy      (o_Rx_Busy)
  );

  // ---------------- clock ----------------
  always #5 i_Clock = ~i_Clock;

  // ---------------- scoreboard state ----------------
  int unsigned cyc        = 0;
  int          errors     = 0;
  int          checks     = 0;
  int          dv_count   = 0;
  int          ferr_count = 0;
  logic [W-1:0] exp_q[$];

  logic [7:0]   m_byte    = 8'h00;
  logic         m_ready   = 1'b0;
  logic         m_overrun = 1'b0;
  logic         ack_s, rst_s, exp_dv, exp_ferr;
  logic [W-1:0] ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Compare process: advance the model at each edge, check outputs #1 later.
  initial begin
    forever begin
      @(posedge i_Clock);
      cyc++;
      ack_s    = i_Rx_Ack;
      rst_s    = i_Rst_n;
      exp_dv   = 1'b0;
      exp_ferr = 1'b0;
      if (!rst_s) begin
        m_byte    = 8'h00;
        m_ready   = 1'b0;
        m_overrun = 1'b0;
        exp_q.delete();
      end else if (exp_q.size() > 0 && exp_q[0][W-1:9] == cyc) begin
        ev = exp_q.pop_front();
        if (ev[8]) begin
          exp_dv = 1'b1;
          if (ack_s) m_overrun = 1'b0;
          else if (m_ready) m_overrun = 1'b1;
          m_byte  = ev[7:0];
          m_ready = 1'b1;
        end else begin
          exp_ferr = 1'b1;
          if (ack_s) begin
            m_ready   = 1'b0;
            m_overrun = 1'b0;
          end
        end
      end else if (ack_s) begin
        m_ready   = 1'b0;
        m_overrun = 1'b0;
      end
      #1;
      if (o_Rx_DV === 1'b1) dv_count++;
      if (o_Rx_Frame_Err === 1'b1) ferr_count++;
      check($sformatf("outputs@%0d", cyc),
            {20'd0, o_Rx_DV, o_Rx_Frame_Err, o_Rx_Ready, o_Rx_Overrun, o_Rx_Byte},
            {20'd0, exp_dv, exp_ferr, m_ready, m_overrun, m_byte});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  // Call at a negedge; returns at a negedge with the line high.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int hold_low);
    exp_q.push_back({32'(cyc + LAT), stop_val, b});
    i_Rx_Serial = 1'b0;
    repeat (CLKS) @(negedge i_Clock);
    for (int i = 0; i < 8; i++) begin
      i_Rx_Serial = b[i];
      repeat (CLKS) @(negedge i_Clock);
    end
    i_Rx_Serial = stop_val;
    repeat (CLKS) @(negedge i_Clock);
    repeat (hold_low) @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
  endtask

  task automatic pulse_ack();
    i_Rx_Ack = 1'b1;
    @(negedge i_Clock);
    i_Rx_Ack = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {26'd0, o_Rx_DV, o_Rx_Frame_Err, o_Rx_Ready, o_Rx_Overrun, o_Rx_Busy,
                 |o_Rx_Byte}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge i_Clock);
    i_Rst_n = 1'b0;
    idle(2);
    check_all_zero("reset_state");
    i_Rst_n = 1'b1;
    idle(2);
  endtask

  // ---------------- directed tests ----------------
  int  n0;
  int  lat;
  logic saw_busy;
  logic [7:0] rb;

  initial begin
    // Reset
    idle(3);
    check_all_zero("initial_reset");
    i_Rst_n = 1'b1;
    idle(3);

    // Clean 0xA5 with exact latency
    dv_count = 0; ferr_count = 0; lat = -1;
    n0 = int'(cyc);
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        for (int k = 1; k <= 400; k++) begin
          @(posedge i_Clock); #2;
          if (o_Rx_DV === 1'b1) begin
            lat = int'(cyc) - n0;
            break;
          end
        end
      end
    join
    idle(10);
    check("a5_latency", lat, 155);
    check("a5_byte", o_Rx_Byte, 8'hA5);
    check("a5_ready", o_Rx_Ready, 1);
    check("a5_dv_count", dv_count, 1);
    check("a5_ferr_count", ferr_count, 0);
    check("a5_busy_idle", o_Rx_Busy, 0);

    // Short low glitch is rejected
    dv_count = 0; ferr_count = 0; saw_busy = 1'b0;
    fork
      begin
        i_Rx_Serial = 1'b0;
        idle(5);
        i_Rx_Serial = 1'b1;
      end
      begin
        for (int k = 1; k <= 12; k++) begin
          @(posedge i_Clock); #2;
          if (o_Rx_Busy === 1'b1) saw_busy = 1'b1;
        end
      end
    join
    check("glitch_saw_busy", saw_busy, 1);
    check("glitch_busy_back", o_Rx_Busy, 0);
    idle(40);
    check("glitch_dv_count", dv_count, 0);
    check("glitch_ferr_count", ferr_count, 0);

    // Framing error with break, then recovery
    do_reset();
    dv_count = 0; ferr_count = 0;
    send_frame(8'h3C, 1'b0, 3 * CLKS);
    idle(20);
    check("ferr_count", ferr_count, 1);
    check("ferr_dv_count", dv_count, 0);
    check("ferr_ready", o_Rx_Ready, 0);
    check("ferr_byte", o_Rx_Byte, 8'h00);
    send_frame(8'h81, 1'b1, 0);
    idle(10);
    check("after_ferr_byte", o_Rx_Byte, 8'h81);
    check("after_ferr_dv", dv_count, 1);
    check("after_ferr_err", ferr_count, 1);

    // Back-to-back frames, no ack -> overrun
    pulse_ack();
    idle(3);
    dv_count = 0;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    idle(10);
    check("b2b_dv_count", dv_count, 2);
    check("b2b_byte", o_Rx_Byte, 8'h22);
    check("b2b_overrun", o_Rx_Overrun, 1);
    check("b2b_ready", o_Rx_Ready, 1);
    pulse_ack();
    idle(2);
    check("b2b_ack_ready", o_Rx_Ready, 0);
    check("b2b_ack_overrun", o_Rx_Overrun, 0);

    // Ack landing on the same edge as a new byte
    send_frame(8'h44, 1'b1, 0);
    idle(5);
    pulse_ack();
    idle(5);
    check("ack44_ready", o_Rx_Ready, 0);
    n0 = int'(cyc);
    fork
      send_frame(8'h55, 1'b1, 0);
      begin
        while (int'(cyc) < n0 + LAT - 1) @(negedge i_Clock);
        pulse_ack();
      end
    join
    idle(3);
    check("ack55_ready", o_Rx_Ready, 1);
    check("ack55_byte", o_Rx_Byte, 8'h55);
    check("ack55_overrun", o_Rx_Overrun, 0);

    // Reset during data bit 4 of 0x77
    rb = 8'h77;
    dv_count = 0; ferr_count = 0;
    i_Rx_Serial = 1'b0;
    idle(CLKS);
    for (int i = 0; i < 4; i++) begin
      i_Rx_Serial = rb[i];
      idle(CLKS);
    end
    i_Rx_Serial = rb[4];
    idle(CLKS / 2);
    i_Rst_n = 1'b0;
    @(posedge i_Clock); #2;
    check_all_zero("midframe_reset");
    @(negedge i_Clock);
    i_Rst_n = 1'b1;
    i_Rx_Serial = 1'b1;
    idle(120);
    check("rst_abort_dv", dv_count, 0);
    check("rst_abort_ferr", ferr_count, 0);
    check("rst_abort_busy", o_Rx_Busy, 0);
    send_frame(8'h5A, 1'b1, 0);
    idle(10);
    check("after_rst_byte", o_Rx_Byte, 8'h5A);
    check("after_rst_dv", dv_count, 1);

    check("pending_events", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends with a summary.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got no completion, expected finish before 2000000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
